// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// Drives pipeline-register write enables, bubble/flush selects and PC write
// enable; tracks outstanding memory accesses and counts lost cycles.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_use_stall_i,
  input  logic             br_taken_i,
  input  logic             imem_stall_i,
  input  logic             imem_done_i,
  input  logic             dmem_stall_i,
  input  logic             dmem_done_i,
  input  logic             halt_wb_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             idex_we_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             memwb_bubble_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ibusy_q, ibusy_d;
  logic             dbusy_q, dbusy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze_c;
  logic             cnt_inc_c;

  // A memory access is outstanding from its stall cycle until its done pulse.
  assign freeze_c = imem_stall_i | dmem_stall_i
                  | (ibusy_q & ~imem_done_i) | (dbusy_q & ~dmem_done_i);

  // Next-state and prioritised enable/bubble decode.
  always_comb begin
    state_d        = state_q;
    ibusy_d        = ibusy_q;
    dbusy_d        = dbusy_q;
    cnt_d          = cnt_q;
    cnt_inc_c      = 1'b0;
    pc_we_o        = 1'b0;
    ifid_we_o      = 1'b0;
    idex_we_o      = 1'b0;
    exmem_we_o     = 1'b0;
    memwb_we_o     = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    halted_o       = 1'b0;

    // Done wins over a simultaneous stall: the access has completed.
    if (imem_done_i)       ibusy_d = 1'b0;
    else if (imem_stall_i) ibusy_d = 1'b1;
    if (dmem_done_i)       dbusy_d = 1'b0;
    else if (dmem_stall_i) dbusy_d = 1'b1;

    if (!rst_i) begin
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (state_q == ST_HALT) begin
      halted_o = 1'b1;
    end else if (freeze_c) begin
      // WB retires a NOP so the frozen instruction is not written twice.
      memwb_we_o     = 1'b1;
      memwb_bubble_o = 1'b1;
      cnt_inc_c      = 1'b1;
    end else if (br_taken_i) begin
      pc_we_o       = 1'b1;
      ifid_we_o     = 1'b1;
      idex_we_o     = 1'b1;
      exmem_we_o    = 1'b1;
      memwb_we_o    = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (ld_use_stall_i) begin
      idex_we_o     = 1'b1;
      exmem_we_o    = 1'b1;
      memwb_we_o    = 1'b1;
      idex_bubble_o = 1'b1;
      cnt_inc_c     = 1'b1;
    end else begin
      pc_we_o    = 1'b1;
      ifid_we_o  = 1'b1;
      idex_we_o  = 1'b1;
      exmem_we_o = 1'b1;
      memwb_we_o = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (freeze_c)       state_d = ST_WAIT;
        else if (halt_wb_i) state_d = ST_HALT;
      end
      ST_WAIT: begin
        if (!freeze_c) state_d = ST_RUN;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase

    if (cnt_inc_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // State, busy flags and counter with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      ibusy_q <= 1'b0;
      dbusy_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ibusy_q <= ibusy_d;
      dbusy_q <= dbusy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: directed vectors, a behavioural model checked
// every cycle, and literal expectations at key points.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst, lu, br, is, id, ds, dd, hw;

  logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fl, a_ib, a_mb, a_h;
  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fl, b_ib, b_mb, b_h;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .ld_use_stall_i(lu), .br_taken_i(br),
    .imem_stall_i(is), .imem_done_i(id), .dmem_stall_i(ds), .dmem_done_i(dd),
    .halt_wb_i(hw), .pc_we_o(a_pc), .ifid_we_o(a_ifid), .idex_we_o(a_idex),
    .exmem_we_o(a_exmem), .memwb_we_o(a_memwb), .ifid_flush_o(a_fl),
    .idex_bubble_o(a_ib), .memwb_bubble_o(a_mb), .halted_o(a_h),
    .stall_cnt_o(a_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .ld_use_stall_i(lu), .br_taken_i(br),
    .imem_stall_i(is), .imem_done_i(id), .dmem_stall_i(ds), .dmem_done_i(dd),
    .halt_wb_i(hw), .pc_we_o(b_pc), .ifid_we_o(b_ifid), .idex_we_o(b_idex),
    .exmem_we_o(b_exmem), .memwb_we_o(b_memwb), .ifid_flush_o(b_fl),
    .idex_bubble_o(b_ib), .memwb_bubble_o(b_mb), .halted_o(b_h),
    .stall_cnt_o(b_cnt)
  );

  // Behavioural model: outstanding accesses, halted flag, "was frozen" flag,
  // and an unbounded lost-cycle tally saturated only when compared.
  bit m_halted, m_was_frozen, m_iout, m_dout;
  int m_lost;

  function automatic logic [8:0] expect_ctl(input bit frz);
    // {pc, ifid, idex, exmem, memwb, flush, idex_bub, memwb_bub, halted}
    if (!rst)          return 9'b00000_111_0;
    else if (m_halted) return 9'b00000_000_1;
    else if (frz)      return 9'b00001_001_0;
    else if (br)       return 9'b11111_110_0;
    else if (lu)       return 9'b00111_010_0;
    else               return 9'b11111_000_0;
  endfunction

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    bit frz;
    logic [8:0] e, ga, gb;
    int sat16, sat4;
    frz = is || ds || (m_iout && !id) || (m_dout && !dd);
    e  = expect_ctl(frz);
    ga = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fl, a_ib, a_mb, a_h};
    gb = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fl, b_ib, b_mb, b_h};
    sat16 = (m_lost > 65535) ? 65535 : m_lost;
    sat4  = (m_lost > 15) ? 15 : m_lost;
    total += 4;
    if (ga !== e) begin bad++; $display("FAIL ctl16 t=%0t got=%b want=%b", $time, ga, e); end
    if (gb !== e) begin bad++; $display("FAIL ctl4 t=%0t got=%b want=%b", $time, gb, e); end
    if (a_cnt !== 16'(sat16)) begin bad++; $display("FAIL cnt16 t=%0t got=%0d want=%0d", $time, a_cnt, sat16); end
    if (b_cnt !== 4'(sat4)) begin bad++; $display("FAIL cnt4 t=%0t got=%0d want=%0d", $time, b_cnt, sat4); end
    if (!rst) begin
      m_halted = 0; m_was_frozen = 0; m_iout = 0; m_dout = 0; m_lost = 0;
    end else begin
      if (!m_halted) begin
        if (frz || lu && !br) m_lost++;
        if (frz) m_was_frozen = 1;
        else begin
          if (!m_was_frozen && hw) m_halted = 1;
          m_was_frozen = 0;
        end
      end
      m_iout = id ? 1'b0 : (is ? 1'b1 : m_iout);
      m_dout = dd ? 1'b0 : (ds ? 1'b1 : m_dout);
    end
  end

  // Set inputs just after a rising edge, then wait until the mid-cycle check point.
  task automatic cyc(input logic r, l, b, ist, idn, dst, ddn, h);
    @(posedge clk); #1;
    rst = r; lu = l; br = b; is = ist; id = idn; ds = dst; dd = ddn; hw = h;
    @(negedge clk); #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    rst = 0; lu = 0; br = 0; is = 0; id = 0; ds = 0; dd = 0; hw = 0;
    m_halted = 0; m_was_frozen = 0; m_iout = 0; m_dout = 0; m_lost = 0;
    // reset held two cycles
    @(negedge clk); #2;
    chk("rst_pc_we", a_pc, 0); chk("rst_idex_bub", a_ib, 1); chk("rst_cnt", a_cnt, 0);
    cyc(0,0,0,0,0,0,0,0);
    chk("rst_mwb_bub", a_mb, 1);
    // release
    cyc(1,0,0,0,0,0,0,0);
    chk("rel_pc_we", a_pc, 1); chk("rel_idex_bub", a_ib, 0);
    // load-use
    cyc(1,1,0,0,0,0,0,0);
    chk("lu_pc_we", a_pc, 0); chk("lu_ifid_we", a_ifid, 0);
    chk("lu_idex_bub", a_ib, 1); chk("lu_exmem_we", a_exmem, 1);
    // branch beats load-use
    cyc(1,1,1,0,0,0,0,0);
    chk("br_cnt_before", a_cnt, 1);
    chk("br_pc_we", a_pc, 1); chk("br_flush", a_fl, 1); chk("br_idex_bub", a_ib, 1);
    cyc(1,0,0,0,0,0,0,0);
    chk("br_cnt_after", a_cnt, 1);
    // data miss: 3 stall cycles then done
    for (int k = 0; k < 3; k++) begin
      cyc(1,0,0,0,0,1,0,0);
      chk("dmiss_pc_we", a_pc, 0); chk("dmiss_exmem_we", a_exmem, 0);
      chk("dmiss_mwb_bub", a_mb, 1);
    end
    cyc(1,0,0,0,0,0,1,0);
    chk("ddone_pc_we", a_pc, 1); chk("ddone_memwb_we", a_memwb, 1);
    cyc(1,0,0,0,0,0,0,0);
    chk("dmiss_cnt", a_cnt, 4);
    // halt_wb arriving on the WAIT exit cycle is ignored
    cyc(1,0,0,0,0,1,0,0);
    cyc(1,0,0,0,0,0,1,1);
    cyc(1,0,0,0,0,0,0,0);
    chk("wait_halt_ignored", a_h, 0); chk("wait_cnt", a_cnt, 5);
    // overlapping memories with branch held through the freeze
    cyc(1,0,1,1,0,0,0,0); chk("ov0_pc_we", a_pc, 0);
    cyc(1,0,1,1,0,1,0,0); chk("ov1_pc_we", a_pc, 0);
    cyc(1,0,1,0,1,1,0,0); chk("ov2_pc_we", a_pc, 0);
    cyc(1,0,1,0,0,1,0,0); chk("ov3_flush", a_fl, 0);
    cyc(1,0,1,0,0,1,0,0); chk("ov4_pc_we", a_pc, 0);
    cyc(1,0,1,0,0,0,1,0);
    chk("ov5_pc_we", a_pc, 1); chk("ov5_flush", a_fl, 1); chk("ov5_idex_bub", a_ib, 1);
    cyc(1,0,0,0,0,0,0,0);
    chk("ov_cnt", a_cnt, 10);
    // halt
    cyc(1,0,0,0,0,0,0,1);
    chk("halt_same_cycle", a_h, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1,(k == 3),0,0,0,0,0,0);
      chk("halted", a_h, 1); chk("halt_pc_we", a_pc, 0); chk("halt_memwb_we", a_memwb, 0);
    end
    chk("halt_cnt_frozen", a_cnt, 10);
    cyc(0,0,0,0,0,0,0,0);
    chk("halt_rst_halted", a_h, 0);
    cyc(1,0,0,0,0,0,0,0);
    chk("post_halt_cnt", a_cnt, 0); chk("post_halt_pc_we", a_pc, 1);
    // saturation on the narrow counter
    for (int k = 0; k < 20; k++) cyc(1,1,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0);
    chk("sat_cnt4", b_cnt, 15); chk("sat_cnt16", a_cnt, 20);
    // reset in the middle of a WAIT
    cyc(1,0,0,0,0,1,0,0);
    cyc(0,0,0,0,0,1,0,0);
    cyc(1,0,0,0,0,0,0,0);
    chk("rst_wait_pc_we", a_pc, 1); chk("rst_wait_cnt", a_cnt, 0);
    cyc(1,0,0,0,0,0,0,0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the 5-stage pipeline. It consumes the load-use stall request from hazard detection, taken-branch redirects from EX, multi-cycle instruction/data memory handshakes, and halt from WB. It drives every pipeline-register write enable and bubble/flush select, plus the PC write enable. It owns the freeze state machine and a saturating stall-cycle counter.

## Interface
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset; one clock, no other clock domains
- ld_use_stall  in  1  load-use hazard present (ID consumer of EX load)
- br_taken  in  1  EX resolved a taken branch/jump this cycle
- imem_stall  in  1  instruction memory access not complete this cycle
- imem_done  in  1  one-cycle pulse, fetch data valid (held by memory until next request)
- dmem_stall  in  1  data memory access not complete this cycle
- dmem_done  in  1  one-cycle pulse, load data/store complete (held until next request)
- halt_wb  in  1  HALT instruction in WB
- pc_we  out  1  PC register write enable
- ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipeline register write enables
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP/zero control into ID/EX
- memwb_bubble  out  1  load NOP into MEM/WB
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  cycles lost to freeze or load-use, saturating

## Operation
- States: RUN, WAIT, HALT. Registers: state, ibusy, dbusy, stall_cnt.
- ibusy set on cycle imem_stall=1, cleared on cycle imem_done=1 (done wins if both). dbusy likewise with dmem_*.
- freeze = imem_stall | dmem_stall | (ibusy & ~imem_done) | (dbusy & ~dmem_done).
- RUN -> WAIT when freeze=1. WAIT -> RUN when freeze=0. RUN -> HALT when halt_wb=1 and freeze=0. HALT exits only on reset. halt_wb ignored in WAIT.
- Output priority (highest first), combinational from state and inputs:
  1. rst=0: all *_we=0, ifid_flush=idex_bubble=memwb_bubble=1, halted=0.
  2. HALT: all *_we=0, bubbles/flush=0, halted=1.
  3. freeze=1 (RUN or WAIT): pc_we=ifid_we=idex_we=exmem_we=0; memwb_we=1, memwb_bubble=1 (WB sees NOP, no repeated register write).
  4. br_taken=1: all *_we=1, ifid_flush=1, idex_bubble=1 (ld_use_stall ignored; PC loads target).
  5. ld_use_stall=1: pc_we=ifid_we=0; idex_we=exmem_we=memwb_we=1; idex_bubble=1.
  6. Otherwise: all *_we=1, no bubbles.
- br_taken during freeze is not lost: EX is frozen, so br_taken stays asserted and is applied on the first unfrozen cycle.
- stall_cnt increments by 1 each cycle case 3 or case 5 applies; holds at 2^CNT_W-1; cleared only by reset.

## Timing
- Enables/bubbles are the same cycle as the causing input (zero latency); they are sampled by the pipeline registers at the next edge.
- Done cycle: if freeze=0, that cycle advances the whole pipeline (case 4/5/6 apply).
- If both memories are outstanding, the pipeline stays frozen until both have completed. The earlier done is absorbed by clearing its busy flag, and the memory holds its data.
- Reset mid-WAIT: next cycle state=RUN, ibusy=dbusy=0, stall_cnt=0.
- halted asserts the cycle after halt_wb is sampled in RUN without freeze and stays high.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release with no requests -> during reset all we=0, all bubbles=1, stall_cnt=0; first cycle after release all we=1, bubbles=0.
- Load-use: ld_use_stall=1 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1 that cycle; stall_cnt 0->1.
- Branch over load-use: br_taken=1 and ld_use_stall=1 together -> pc_we=1, ifid_flush=1, idex_bubble=1; stall_cnt unchanged.
- Data miss: dmem_stall=1 for 3 cycles, then dmem_done=1 -> 3 cycles with pc_we=exmem_we=0 and memwb_bubble=1, state WAIT; done cycle all we=1; stall_cnt +=3.
- Overlapping memories: imem_stall for cycles 0-1 with imem_done at cycle 2; dmem_stall for cycles 1-4 with dmem_done at cycle 5 -> frozen for cycles 0-4, advances at cycle 5; br_taken held through the freeze -> flush applied at cycle 5.
- Halt and saturation: halt_wb=1 in RUN -> next cycle halted=1 with all we=0, persisting across 10 cycles until rst=0. Separately with CNT_W=4, 20 load-use cycles -> stall_cnt=15.
